// File: rtl/sram_burst_reader.sv
// ============================================================================
// Module   : sram_burst_reader
// Purpose  : Read-side initiator for a single-port synchronous SRAM
//            (1-cycle read latency). On start, streams LEN words beginning
//            at BASE, ascending or descending, out a valid/ready port. A
//            2-entry output buffer hides the SRAM latency, so the stream
//            runs at one word per cycle while outReady stays high.
// Ports    : CLK, reset            - clock, synchronous active-high reset
//            start, baseAddr,
//            length, descend       - burst request (sampled only in IDLE)
//            address, write,
//            dataInput, dataOutput - SRAM side (write/dataInput tied 0)
//            outData, outValid,
//            outReady              - output stream, beat = valid & ready
//            busy, done, error     - status; done/error are 1-cycle pulses
// Config   : SRAM_READER_WRAP_EN - when defined, the start range check is
//            removed, addresses wrap modulo 2^A and error is always 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_reader #(
  parameter int A = 11,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] baseAddr,
  input  logic [A:0]   length,
  input  logic         descend,
  output logic [A-1:0] address,
  output logic         write,
  output logic [W-1:0] dataInput,
  input  logic [W-1:0] dataOutput,
  output logic [W-1:0] outData,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [A:0]   remaining_q, remaining_d;
  logic         desc_q, desc_d;
  logic         in_flight_q, in_flight_d;
  logic [W-1:0] buf0_q, buf0_d;
  logic [W-1:0] buf1_q, buf1_d;
  logic [1:0]   buf_count_q, buf_count_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         error_q, error_d;

  logic         pop;
  logic         issue;
  logic         range_bad;
  logic [2:0]   occupancy;
  logic [A-1:0] addr_step;

  // Start-time range check: a burst may not run past either end of memory.
  // Widened arithmetic so base+len and base+1 cannot overflow.
`ifdef SRAM_READER_WRAP_EN
  assign range_bad = 1'b0;
`else
  logic [A+1:0] asc_end;
  logic [A:0]   desc_room;
  assign asc_end   = {2'b00, baseAddr} + {1'b0, length};
  assign desc_room = {1'b0, baseAddr} + {{A{1'b0}}, 1'b1};
  assign range_bad = descend ? (length > desc_room)
                             : (asc_end > ({{(A+1){1'b0}}, 1'b1} << A));
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    desc_d      = desc_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_count_d = buf_count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    pop = (buf_count_q != 2'd0) && outReady;

    // A read issued now lands in the buffer two edges later; allow it only
    // if the buffer is guaranteed a free slot by then.
    occupancy   = {1'b0, buf_count_q} + {2'b00, in_flight_q};
    issue       = (state_q == S_ISSUE) && (occupancy < (3'd2 + {2'b00, pop}));
    in_flight_d = issue;

    addr_step = desc_q ? (addr_q - {{(A-1){1'b0}}, 1'b1})
                       : (addr_q + {{(A-1){1'b0}}, 1'b1});

    // In-order 2-entry FIFO: buf0 is always the head.
    unique case ({in_flight_q, pop})
      2'b10: begin
        if (buf_count_q == 2'd0) buf0_d = dataOutput;
        else                     buf1_d = dataOutput;
        buf_count_d = buf_count_q + 2'd1;
      end
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b11: begin
        if (buf_count_q == 2'd1) begin
          buf0_d = dataOutput;
        end else begin
          buf0_d = buf1_q;
          buf1_d = dataOutput;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_d = 1'b1;
          end else begin
            addr_d      = baseAddr;
            remaining_d = length;
            desc_d      = descend;
            busy_d      = 1'b1;
            state_d     = (length == '0) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          remaining_d = remaining_q - {{A{1'b0}}, 1'b1};
          // Hold the last address rather than stepping past the burst end.
          if (remaining_q == {{A{1'b0}}, 1'b1}) state_d = S_DRAIN;
          else                                  addr_d  = addr_step;
        end
      end
      S_DRAIN: begin
        // Look at next-cycle occupancy so done follows the last beat directly.
        if ((buf_count_d == 2'd0) && !in_flight_d) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      desc_q      <= 1'b0;
      in_flight_q <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      buf_count_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      desc_q      <= desc_d;
      in_flight_q <= in_flight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf_count_q <= buf_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign address   = addr_q;
  assign write     = 1'b0;
  assign dataInput = '0;
  assign outData   = buf0_q;
  assign outValid  = (buf_count_q != 2'd0);
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_reader.sv
// ============================================================================
// Module   : tb_sram_burst_reader
// Purpose  : Self-checking bench for sram_burst_reader. A behavioural SRAM
//            (mem[i] = i, 1-cycle sync read) feeds the DUT; expected words
//            are queued when a burst is requested and a monitor pops and
//            compares on every stream beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_burst_reader;

  localparam int A = 11;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [A-1:0] baseAddr = '0;
  logic [A:0]   length = '0;
  logic         descend = 1'b0;
  logic [A-1:0] address;
  logic         write;
  logic [W-1:0] dataInput;
  logic [W-1:0] dataOutput = '0;
  logic [W-1:0] outData;
  logic         outValid;
  logic         outReady = 1'b1;
  logic         busy;
  logic         done;
  logic         error;

  sram_burst_reader #(.A(A), .W(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .baseAddr(baseAddr),
    .length(length), .descend(descend), .address(address), .write(write),
    .dataInput(dataInput), .dataOutput(dataOutput), .outData(outData),
    .outValid(outValid), .outReady(outReady), .busy(busy), .done(done),
    .error(error)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] mem [0:(1<<A)-1];
  initial for (int i = 0; i < (1 << A); i++) mem[i] = W'(i);
  always @(posedge CLK) dataOutput <= mem[address];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [W-1:0] exp_q[$];

  logic rdy_mode = 1'b0;
  int   pidx = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Ready driver: always-ready, or the repeating 1,0,0,1,0,1 pattern.
  initial forever begin
    @(posedge CLK);
    #1;
    if (rdy_mode) begin
      outReady = pat[pidx];
      pidx = (pidx + 1) % 6;
    end else begin
      outReady = 1'b1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  initial forever begin
    @(negedge CLK);
    if (stall_prev) begin
      total++;
      if (!(outValid === 1'b1 && outData === stall_data)) begin
        bad++;
        $display("FAIL stall_hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                 outValid, outData, stall_data);
      end
    end
    if (outValid === 1'b1 && outReady === 1'b1) begin
      beat_cnt++;
      if (beat_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_beat: got data=%0d expected no beat", outData);
      end else begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        if (outData !== e) begin
          bad++;
          $display("FAIL beat_data: got %0d expected %0d", outData, e);
        end
      end
    end
    stall_prev = (outValid === 1'b1) && (outReady === 1'b0) && !reset;
    stall_data = outData;
  end

  // Issue a start pulse; returns #1 after the edge that samples it (E0).
  task automatic start_burst(input logic [A-1:0] b, input logic [A:0] l, input logic d);
    @(posedge CLK); #1;
    baseAddr = b; length = l; descend = d; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    total++;
    if (dcyc < 0) begin
      bad++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
    end else begin
      chk({name, "_busy_at_done"}, busy, 0);
      @(negedge CLK);
      chk({name, "_done_pulse"}, done, 0);
    end
  endtask

  task automatic new_test();
    exp_q.delete();
    beat_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_address", address, 0);
    chk("rst_outData", outData, 0);
    chk("rst_write", write, 0);
    chk("rst_dataInput", dataInput, 0);
    reset = 1'b0;

    // 1: base 0, len 8, ascending, full rate
    new_test();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i));
    start_burst(11'd0, 12'd8, 1'b0);
    chk("t1_busy", busy, 1);
    @(posedge CLK); #1;
    chk("t1_valid_E1", outValid, 0);
    @(posedge CLK); #1;
    chk("t1_valid_E2", outValid, 1);
    chk("t1_data_E2", outData, 0);
    wait_done("t1", 100, dc);
    chk("t1_beats", beat_cnt, 8);
    chk("t1_consecutive", last_cyc - first_cyc, 7);
    chk("t1_done_lag", dc - last_cyc, 1);
    chk("t1_queue_left", exp_q.size(), 0);

    // 2: base 2047, len 2048, descending
    new_test();
    for (int i = 2047; i >= 0; i--) exp_q.push_back(W'(i));
    start_burst(11'd2047, 12'd2048, 1'b1);
    chk("t2_error", error, 0);
    chk("t2_busy", busy, 1);
    wait_done("t2", 2200, dc);
    chk("t2_beats", beat_cnt, 2048);
    chk("t2_full_rate", last_cyc - first_cyc, 2047);
    chk("t2_queue_left", exp_q.size(), 0);

    // 3: base 10, len 6, ascending, ready toggling
    new_test();
    pidx = 0;
    rdy_mode = 1'b1;
    for (int i = 10; i < 16; i++) exp_q.push_back(W'(i));
    start_burst(11'd10, 12'd6, 1'b0);
    wait_done("t3", 200, dc);
    chk("t3_beats", beat_cnt, 6);
    chk("t3_queue_left", exp_q.size(), 0);
    rdy_mode = 1'b0;

    // 4: zero-length burst
    new_test();
    start_burst(11'd5, 12'd0, 1'b0);
    chk("t4_busy", busy, 1);
    @(posedge CLK); #1;
    chk("t4_done", done, 1);
    chk("t4_busy_off", busy, 0);
    @(posedge CLK); #1;
    chk("t4_done_off", done, 0);
    chk("t4_beats", beat_cnt, 0);

    // 5: burst crossing the top of memory
    new_test();
`ifdef SRAM_READER_WRAP_EN
    for (int i = 2040; i < 2048; i++) exp_q.push_back(W'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i));
    start_burst(11'd2040, 12'd16, 1'b0);
    chk("t5_error", error, 0);
    wait_done("t5", 200, dc);
    chk("t5_beats", beat_cnt, 16);
    chk("t5_queue_left", exp_q.size(), 0);
`else
    start_burst(11'd2040, 12'd16, 1'b0);
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 0);
    @(posedge CLK); #1;
    chk("t5_error_off", error, 0);
    chk("t5_busy_idle", busy, 0);
    chk("t5_no_valid", outValid, 0);
    repeat (4) @(posedge CLK);
    #1;
    chk("t5_beats", beat_cnt, 0);
`endif

    // 6: reset mid-burst, then a fresh burst
    new_test();
    for (int i = 100; i < 120; i++) exp_q.push_back(W'(i));
    start_burst(11'd100, 12'd20, 1'b0);
    for (int i = 0; i < 50 && beat_cnt < 3; i++) @(negedge CLK);
    chk("t6_three_beats", beat_cnt >= 3, 1);
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("t6_rst_valid", outValid, 0);
    chk("t6_rst_busy", busy, 0);
    reset = 1'b0;
    new_test();
    for (int i = 5; i < 9; i++) exp_q.push_back(W'(i));
    start_burst(11'd5, 12'd4, 1'b0);
    wait_done("t6", 100, dc);
    chk("t6_beats", beat_cnt, 4);
    chk("t6_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
